// File: rtl/bp_hard_mem_pkg.sv
// Shared types and helpers for the banked fakeram130 1RW memory wrappers.
package bp_hard_mem_pkg;

  typedef enum logic [2:0] {
    e_512x64,
    e_256x95,
    e_64x96,
    e_64x15,
    e_64x7,
    e_geom_none
  } macro_geom_e;

  typedef enum logic [0:0] {
    e_init,
    e_ready
  } state_e;

  // Widest write mask the expansion helper can take.
  localparam int max_mask_w_gp = 4096;

  function automatic macro_geom_e geom_of(input int els, input int width);
    if (els == 512 && width == 64) return e_512x64;
    if (els == 256 && width == 95) return e_256x95;
    if (els == 64  && width == 96) return e_64x96;
    if (els == 64  && width == 15) return e_64x15;
    if (els == 64  && width == 7)  return e_64x7;
    return e_geom_none;
  endfunction

  // Bit-level write enable: the coarse mask bit covering bit_idx, gated by the write strobe.
  function automatic logic mask_bit(input logic [max_mask_w_gp-1:0] mask, input int bit_idx,
                                    input int gran, input logic w);
    return w & (|(mask & (max_mask_w_gp'(1) << (bit_idx / gran))));
  endfunction

endpackage

// File: rtl/fakeram130_256x95.sv
// Behavioural model of the fakeram130 256x95 1RW macro (registered read, bit write mask).
module fakeram130_256x95 (
`ifdef USE_POWER_PINS
  inout  wire         vccd1,
  inout  wire         vssd1,
`endif
  input  logic        clk,
  input  logic        ce_in,
  input  logic        we_in,
  input  logic [7:0]  addr_in,
  input  logic [94:0] wd_in,
  input  logic [94:0] w_mask_in,
  output logic [94:0] rd_out
);
  logic [94:0] mem [256];

  always_ff @(posedge clk) begin
    if (ce_in) begin
      if (we_in) mem[addr_in] <= (mem[addr_in] & ~w_mask_in) | (wd_in & w_mask_in);
      else       rd_out <= mem[addr_in];
    end
  end
endmodule

// File: rtl/fakeram130_512x64.sv
// Behavioural model of the fakeram130 512x64 1RW macro (registered read, bit write mask).
module fakeram130_512x64 (
`ifdef USE_POWER_PINS
  inout  wire         vccd1,
  inout  wire         vssd1,
`endif
  input  logic        clk,
  input  logic        ce_in,
  input  logic        we_in,
  input  logic [8:0]  addr_in,
  input  logic [63:0] wd_in,
  input  logic [63:0] w_mask_in,
  output logic [63:0] rd_out
);
  logic [63:0] mem [512];

  always_ff @(posedge clk) begin
    if (ce_in) begin
      if (we_in) mem[addr_in] <= (mem[addr_in] & ~w_mask_in) | (wd_in & w_mask_in);
      else       rd_out <= mem[addr_in];
    end
  end
endmodule

// File: rtl/fakeram130_64x15.sv
// Behavioural model of the fakeram130 64x15 1RW macro (registered read, bit write mask).
module fakeram130_64x15 (
`ifdef USE_POWER_PINS
  inout  wire         vccd1,
  inout  wire         vssd1,
`endif
  input  logic        clk,
  input  logic        ce_in,
  input  logic        we_in,
  input  logic [5:0]  addr_in,
  input  logic [14:0] wd_in,
  input  logic [14:0] w_mask_in,
  output logic [14:0] rd_out
);
  logic [14:0] mem [64];

  always_ff @(posedge clk) begin
    if (ce_in) begin
      if (we_in) mem[addr_in] <= (mem[addr_in] & ~w_mask_in) | (wd_in & w_mask_in);
      else       rd_out <= mem[addr_in];
    end
  end
endmodule

// File: rtl/fakeram130_64x7.sv
// Behavioural model of the fakeram130 64x7 1RW macro (registered read, bit write mask).
module fakeram130_64x7 (
`ifdef USE_POWER_PINS
  inout  wire        vccd1,
  inout  wire        vssd1,
`endif
  input  logic       clk,
  input  logic       ce_in,
  input  logic       we_in,
  input  logic [5:0] addr_in,
  input  logic [6:0] wd_in,
  input  logic [6:0] w_mask_in,
  output logic [6:0] rd_out
);
  logic [6:0] mem [64];

  always_ff @(posedge clk) begin
    if (ce_in) begin
      if (we_in) mem[addr_in] <= (mem[addr_in] & ~w_mask_in) | (wd_in & w_mask_in);
      else       rd_out <= mem[addr_in];
    end
  end
endmodule

// File: rtl/fakeram130_64x96.sv
// Behavioural model of the fakeram130 64x96 1RW macro (registered read, bit write mask).
module fakeram130_64x96 (
`ifdef USE_POWER_PINS
  inout  wire         vccd1,
  inout  wire         vssd1,
`endif
  input  logic        clk,
  input  logic        ce_in,
  input  logic        we_in,
  input  logic [5:0]  addr_in,
  input  logic [95:0] wd_in,
  input  logic [95:0] w_mask_in,
  output logic [95:0] rd_out
);
  logic [95:0] mem [64];

  always_ff @(posedge clk) begin
    if (ce_in) begin
      if (we_in) mem[addr_in] <= (mem[addr_in] & ~w_mask_in) | (wd_in & w_mask_in);
      else       rd_out <= mem[addr_in];
    end
  end
endmodule

// File: rtl/hard_mem_fakeram130_sel.sv
// Picks the fakeram130 hard macro matching the requested (depth, width) geometry.
module hard_mem_fakeram130_sel
  import bp_hard_mem_pkg::*;
#(
  parameter int macro_els_p   = 512,
  parameter int macro_width_p = 64
) (
`ifdef USE_POWER_PINS
  inout  wire                           vccd1,
  inout  wire                           vssd1,
`endif
  input  logic                          clk_i,
  input  logic                          ce_i,
  input  logic                          we_i,
  input  logic [$clog2(macro_els_p)-1:0] addr_i,
  input  logic [macro_width_p-1:0]      wd_i,
  input  logic [macro_width_p-1:0]      w_mask_i,
  output logic [macro_width_p-1:0]      rd_o
);
  localparam macro_geom_e geom_lp = geom_of(macro_els_p, macro_width_p);

  case (geom_lp)
    e_512x64: begin : g_512x64
      fakeram130_512x64 u_macro (
`ifdef USE_POWER_PINS
        .vccd1(vccd1), .vssd1(vssd1),
`endif
        .clk(clk_i), .ce_in(ce_i), .we_in(we_i), .addr_in(addr_i),
        .wd_in(wd_i), .w_mask_in(w_mask_i), .rd_out(rd_o));
    end
    e_256x95: begin : g_256x95
      fakeram130_256x95 u_macro (
`ifdef USE_POWER_PINS
        .vccd1(vccd1), .vssd1(vssd1),
`endif
        .clk(clk_i), .ce_in(ce_i), .we_in(we_i), .addr_in(addr_i),
        .wd_in(wd_i), .w_mask_in(w_mask_i), .rd_out(rd_o));
    end
    e_64x96: begin : g_64x96
      fakeram130_64x96 u_macro (
`ifdef USE_POWER_PINS
        .vccd1(vccd1), .vssd1(vssd1),
`endif
        .clk(clk_i), .ce_in(ce_i), .we_in(we_i), .addr_in(addr_i),
        .wd_in(wd_i), .w_mask_in(w_mask_i), .rd_out(rd_o));
    end
    e_64x15: begin : g_64x15
      fakeram130_64x15 u_macro (
`ifdef USE_POWER_PINS
        .vccd1(vccd1), .vssd1(vssd1),
`endif
        .clk(clk_i), .ce_in(ce_i), .we_in(we_i), .addr_in(addr_i),
        .wd_in(wd_i), .w_mask_in(w_mask_i), .rd_out(rd_o));
    end
    e_64x7: begin : g_64x7
      fakeram130_64x7 u_macro (
`ifdef USE_POWER_PINS
        .vccd1(vccd1), .vssd1(vssd1),
`endif
        .clk(clk_i), .ce_in(ce_i), .we_in(we_i), .addr_in(addr_i),
        .wd_in(wd_i), .w_mask_in(w_mask_i), .rd_out(rd_o));
    end
    default: begin : g_unsupported
      $error("hard_mem_fakeram130_sel: unsupported macro geometry");
      assign rd_o = '0;
    end
  endcase
endmodule

// File: rtl/hard_mem_1rw_banked_wrapper.sv
// Single-port 1RW memory tiled from fakeram130 macros: banks in depth, lanes in width,
// optional post-reset zeroing sweep and a read-data hold register.
module hard_mem_1rw_banked_wrapper
  import bp_hard_mem_pkg::*;
#(
  parameter int els_p            = 1024,
  parameter int width_p          = 64,
  parameter int macro_els_p      = 512,
  parameter int macro_width_p    = 64,
  parameter int mask_gran_p      = 8,
  parameter int clear_on_reset_p = 1
) (
`ifdef USE_POWER_PINS
  inout  wire                             vccd1,
  inout  wire                             vssd1,
`endif
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic                            v_i,
  input  logic                            w_i,
  input  logic [$clog2(els_p)-1:0]        addr_i,
  input  logic [width_p-1:0]              data_i,
  input  logic [width_p/mask_gran_p-1:0]  w_mask_i,
  output logic                            ready_o,
  output logic [width_p-1:0]              data_o,
  output logic                            v_o
);
  localparam int banks_lp  = els_p / macro_els_p;
  localparam int lanes_lp  = (width_p + macro_width_p - 1) / macro_width_p;
  localparam int pad_w_lp  = lanes_lp * macro_width_p;
  localparam int addr_w_lp = $clog2(els_p);
  localparam int row_w_lp  = $clog2(macro_els_p);
  localparam int bank_w_lp = (addr_w_lp > row_w_lp) ? addr_w_lp - row_w_lp : 1;

  if (els_p % macro_els_p != 0) begin : g_bad_depth
    $error("els_p must be a multiple of macro_els_p");
  end
  if (width_p % mask_gran_p != 0) begin : g_bad_gran
    $error("mask_gran_p must divide width_p");
  end
  if (geom_of(macro_els_p, macro_width_p) == e_geom_none) begin : g_bad_geom
    $error("unsupported (macro_els_p, macro_width_p) pair");
  end

  state_e                           state_q, state_d;
  logic [row_w_lp-1:0]              clr_cnt_q, clr_cnt_d;
  logic                             ready_q, ready_d;
  logic                             v_q, v_d;
  logic [width_p-1:0]               hold_q, hold_d;
  logic [bank_w_lp-1:0]             bank_q, bank_idx;
  logic                             oor_q;
  logic                             init, access, in_range;
  logic [row_w_lp-1:0]              row, mac_addr;
  logic                             mac_we;
  logic [width_p-1:0]               bit_mask, rd_data;
  logic [pad_w_lp-1:0]              wd_pad, mask_pad, mac_wd, mac_mask;
  logic [banks_lp-1:0][pad_w_lp-1:0] bank_rd;

  assign row = addr_i[row_w_lp-1:0];
  if (addr_w_lp > row_w_lp) begin : g_bank_bits
    assign bank_idx = addr_i[addr_w_lp-1:row_w_lp];
  end else begin : g_one_bank
    assign bank_idx = '0;
  end

  // Only a non-power-of-two bank count leaves addresses with no backing macro.
  if (banks_lp == 1 || banks_lp == (1 << bank_w_lp)) begin : g_full_range
    assign in_range = 1'b1;
  end else begin : g_part_range
    assign in_range = (bank_idx < bank_w_lp'(banks_lp));
  end

  assign init   = (state_q == e_init);
  assign access = v_i & ready_q;

  for (genvar i = 0; i < width_p; i++) begin : g_mask
    assign bit_mask[i] = mask_bit(max_mask_w_gp'(w_mask_i), i, mask_gran_p, w_i);
  end

  assign wd_pad   = pad_w_lp'(data_i);
  assign mask_pad = pad_w_lp'(bit_mask);

  // The clear sweep drives every macro with a full-mask zero write at the counter row.
  assign mac_we   = init | w_i;
  assign mac_addr = init ? clr_cnt_q : row;
  assign mac_wd   = init ? '0 : wd_pad;
  assign mac_mask = init ? '1 : mask_pad;

  for (genvar b = 0; b < banks_lp; b++) begin : g_bank
    logic ce;
    assign ce = init | (access & in_range & (bank_idx == bank_w_lp'(b)));
    for (genvar l = 0; l < lanes_lp; l++) begin : g_lane
      hard_mem_fakeram130_sel #(
        .macro_els_p  (macro_els_p),
        .macro_width_p(macro_width_p)
      ) u_mem (
`ifdef USE_POWER_PINS
        .vccd1   (vccd1),
        .vssd1   (vssd1),
`endif
        .clk_i   (clk_i),
        .ce_i    (ce),
        .we_i    (mac_we),
        .addr_i  (mac_addr),
        .wd_i    (mac_wd[l*macro_width_p +: macro_width_p]),
        .w_mask_i(mac_mask[l*macro_width_p +: macro_width_p]),
        .rd_o    (bank_rd[b][l*macro_width_p +: macro_width_p])
      );
    end
  end

  always_comb begin
    rd_data = '0;
    if (!oor_q) rd_data = bank_rd[bank_q][width_p-1:0];
  end

  assign data_o  = v_q ? rd_data : hold_q;
  assign v_o     = v_q;
  assign ready_o = ready_q;

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    if (init) begin
      clr_cnt_d = clr_cnt_q + 1'b1;
      if (clr_cnt_q == row_w_lp'(macro_els_p - 1)) state_d = e_ready;
    end
    ready_d = (state_d == e_ready);
    v_d     = access & ~w_i;
    hold_d  = v_q ? data_o : hold_q;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q   <= (clear_on_reset_p != 0) ? e_init : e_ready;
      clr_cnt_q <= '0;
      ready_q   <= 1'b0;
      v_q       <= 1'b0;
      hold_q    <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      ready_q   <= ready_d;
      v_q       <= v_d;
      hold_q    <= hold_d;
    end
  end

  // Read steering travels with the request; an out-of-range read returns zero.
  always_ff @(posedge clk_i) begin
    bank_q <= bank_idx;
    oor_q  <= ~in_range;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i && access) begin
      assert (in_range) else $error("hard_mem_1rw_banked_wrapper: address out of range");
    end
  end
endmodule
